// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM:
// state enum, opcode values, datapath select encodings and the control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_SEQ    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Full set of datapath controls driven each cycle.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle: IR opcode and memory ready in, every enable
// and select out, plus the current state for debug.
interface multicycle_control_if;

    // Memory handshake: mem_read/mem_write act as a held request; the
    // access completes in the cycle mem_ready is 1, and the request stays
    // asserted and unchanged until then.
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_source, illegal_op, state_dbg
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_source, illegal_op, state_dbg
    );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational output decode: maps the current state (plus mem_ready in
// FETCH and opcode in DECODE) to the datapath control word.
module multicycle_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       rst,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_SEQ;
                // PC and IR only load on the cycle the fetch completes.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = SRCB_IMM_SH2;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = ~is_supported(opcode);
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_BRANCH;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
            default: ctrl = '0;
        endcase

        // Reset kills every enable immediately, without waiting for a clock,
        // so an in-flight write cannot leak past the reset edge.
        if (rst) begin
            ctrl           = '0;
            ctrl.alu_src_b = SRCB_FOUR;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core: state register and
// next-state logic; output decoding lives in multicycle_ctrl_decode.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    multicycle_control_if.master  bus
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (bus.mem_ready) state_next = DECODE;
            end
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = MEM_ADDR;
                    OP_RTYPE:     state_next = EXEC_R;
                    OP_BEQ:       state_next = BRANCH;
                    OP_J:         state_next = JUMP;
                    OP_ADDI:      state_next = ADDI_EX;
                    default:      state_next = FETCH;
                endcase
            end
            MEM_ADDR: begin
                // Opcode is re-examined here to pick the load or store path.
                if (bus.opcode == OP_LW) begin
                    state_next = MEM_RD;
                end else if (bus.opcode == OP_SW) begin
                    state_next = MEM_WR;
                end else begin
                    state_next = FETCH;
                end
            end
            MEM_RD: begin
                if (bus.mem_ready) state_next = MEM_WB;
            end
            MEM_WR: begin
                if (bus.mem_ready) state_next = FETCH;
            end
            EXEC_R:  state_next = R_WB;
            ADDI_EX: state_next = ADDI_WB;
            default: state_next = FETCH;
        endcase
    end

    multicycle_ctrl_decode u_decode (
        .state     (state),
        .opcode    (bus.opcode),
        .mem_ready (bus.mem_ready),
        .rst       (rst),
        .ctrl      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.illegal_op    = ctrl.illegal_op;
    assign bus.state_dbg     = state;

endmodule
